// File: rtl/pifo_shift_queue.sv
// Sorted shift-register PIFO: head holds the minimum rank, ties leave in arrival order.
// Define PIFO_EVICT_EN to accept pushes when full and evict the worst entry.
module pifo_shift_queue #(
  parameter  int DEPTH  = 16,
  parameter  int RANK_W = 16,
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [RANK_W-1:0] push_rank,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [RANK_W-1:0] pop_rank,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              evict_valid,
  output logic [DATA_W-1:0] evict_data
);

  logic [RANK_W-1:0] rank_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [RANK_W-1:0] rank_d [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  vld_d;
  logic [CNT_W-1:0]  cnt_d;

  logic             push_fire;
  logic             pop_fire;
  logic [CNT_W-1:0] ins;
  logic [CNT_W-1:0] pos;

  assign count     = cnt_q;
  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign pop_valid = vld_q[0];
  assign pop_rank  = rank_q[0];
  assign pop_data  = data_q[0];

`ifdef PIFO_EVICT_EN
  assign push_ready = 1'b1;
`else
  assign push_ready = !full | pop_ready;
`endif

  assign push_fire = push_valid & push_ready;
  assign pop_fire  = pop_valid & pop_ready;

  // Equal ranks count as "ahead", so a newcomer lands behind them.
  always_comb begin
    ins = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (rank_q[i] <= push_rank))
        ins = ins + CNT_W'(1);
    end
  end

  assign pos = (ins == '0) ? '0 : ins - CNT_W'(1);

`ifdef PIFO_EVICT_EN
  logic              evict_d;
  logic [DATA_W-1:0] evict_data_d;
  logic              evict_q;
  logic [DATA_W-1:0] evict_data_q;
`endif

  always_comb begin
    rank_d = rank_q;
    data_d = data_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
`ifdef PIFO_EVICT_EN
    evict_d      = 1'b0;
    evict_data_d = '0;
`endif
    if (push_fire && pop_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (CNT_W'(i) < pos) begin
          rank_d[i] = rank_q[i+1];
          data_d[i] = data_q[i+1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == pos) begin
          rank_d[i] = push_rank;
          data_d[i] = push_data;
          vld_d[i]  = 1'b1;
        end
      end
    end else if (pop_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        rank_d[i] = rank_q[i+1];
        data_d[i] = data_q[i+1];
        vld_d[i]  = vld_q[i+1];
      end
      rank_d[DEPTH-1] = '0;
      data_d[DEPTH-1] = '0;
      vld_d[DEPTH-1]  = 1'b0;
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push_fire) begin
`ifdef PIFO_EVICT_EN
      if (full && (ins == CNT_W'(DEPTH))) begin
        evict_d      = 1'b1;
        evict_data_d = push_data;
      end else begin
        if (full) begin
          evict_d      = 1'b1;
          evict_data_d = data_q[DEPTH-1];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
      begin
        cnt_d = cnt_q + CNT_W'(1);
`endif
        for (int i = 1; i < DEPTH; i++) begin
          if (CNT_W'(i) > ins) begin
            rank_d[i] = rank_q[i-1];
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
          end
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == ins) begin
            rank_d[i] = push_rank;
            data_d[i] = push_data;
            vld_d[i]  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rank_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      rank_q <= rank_d;
      data_q <= data_d;
    end
  end

`ifdef PIFO_EVICT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      evict_q      <= 1'b0;
      evict_data_q <= '0;
    end else begin
      evict_q      <= evict_d;
      evict_data_q <= evict_data_d;
    end
  end

  assign evict_valid = evict_q;
  assign evict_data  = evict_data_q;
`else
  assign evict_valid = 1'b0;
  assign evict_data  = '0;
`endif

endmodule

// File: doc/pifo_shift_queue.md
Name: pifo_shift_queue

Overview:
- Parametrised push-in-first-out (PIFO) priority queue for the packet scheduler; next-generation flow scheduler.
- Sorted shift-register array: entry 0 always holds the minimum rank; ties dequeue in arrival order.
- Adds over the previous generation:
  - configurable depth and widths;
  - valid/ready handshakes on both sides;
  - single-cycle concurrent push+pop, including when full;
  - exact occupancy count;
  - optional tail eviction.
- Sits between the classifier/rank computer (push side) and the egress port arbiter (pop side).

Parameters:
- DEPTH, 16, number of entries; must be >= 2.
- RANK_W, 16, rank width in bits; unsigned, smaller rank = higher priority.
- DATA_W, 32, payload width in bits.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived localparam, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- push_valid  in  1  producer offers an element.
- push_ready  out  1  queue can accept this cycle.
- push_rank  in  RANK_W  rank of offered element.
- push_data  in  DATA_W  payload of offered element.
- pop_valid  out  1  head element present.
- pop_ready  in  1  consumer takes head this cycle.
- pop_rank  out  RANK_W  rank of head element.
- pop_data  out  DATA_W  payload of head element.
- count  out  CNT_W  number of valid entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- evict_valid  out  1  one-cycle pulse: an entry was evicted (PIFO_EVICT_EN only; else constant 0).
- evict_data  out  DATA_W  payload of evicted entry (else constant 0).

Behaviour:
- Storage and reset:
  - Arrays rank_q/data_q/vld_q[DEPTH], all registered.
  - Valid entries are contiguous from index 0 and sorted non-decreasing by rank.
  - On rst (synchronous, takes priority over everything): all vld_q=0, count=0, evict_valid=0.
  - Reset values: pop_valid=0, empty=1, full=0, push_ready=1, pop_rank/pop_data=0.
  - rst mid-operation discards all contents; handshakes in that cycle are ignored.
- Fire conditions:
  - push_fire = push_valid & push_ready.
  - pop_fire = pop_valid & pop_ready.
- Outputs:
  - pop_valid = vld_q[0]; pop_rank/pop_data = entry 0, driven straight from registers (no combinational path from push inputs).
  - push_ready = !full | pop_ready (without PIFO_EVICT_EN).
  - push_ready must not depend on push_valid.
- Insert position:
  - ins = number of valid entries with rank <= push_rank, computed combinationally from current state.
  - Equal ranks go behind existing ones, giving FIFO order on ties.
- Push only:
  - Entries at index >= ins shift up by one; new element written at ins; count+1.
- Pop only:
  - All entries shift down by one; vld_q[DEPTH-1] cleared; count-1.
- Push and pop in the same cycle:
  - Net effect is pop first, then insert.
  - Entries 1..ins-1 shift down by one; new element written at ins-1; entries >= ins unchanged; count unchanged.
  - If ins == 0, the new element replaces entry 0 directly.
  - When full, push_ready is high only if pop_ready; occupancy stays DEPTH.
  - Push on empty queue with pop_ready high: pop_valid is 0, so no pop occurs and no bypass. The element appears at the head next cycle.
- Latency: an accepted element is visible on pop_* the cycle after push_fire.
- Ignored requests (no state change, no error flag):
  - push_valid while !push_ready.
  - pop_ready while empty.
- Arithmetic:
  - Rank compare is unsigned, RANK_W bits, no wrap-around handling.
  - count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: PIFO_EVICT_EN.
- When defined:
  - push_ready = 1 whenever full, even without pop_ready.
  - Full, no pop_fire, push_rank < rank_q[DEPTH-1]:
    - element inserted at ins; entry DEPTH-1 shifted out;
    - next cycle evict_valid=1 and evict_data = old tail payload; count stays DEPTH.
  - Full, no pop_fire, push_rank >= tail rank:
    - the incoming element itself is discarded;
    - next cycle evict_valid=1 and evict_data = push_data.
  - Full with pop_fire: behaves as normal push+pop, no eviction.
  - evict_valid is registered and lasts exactly one cycle per event.
- When undefined:
  - no eviction logic is compiled;
  - evict_valid and evict_data are tied to 0.

Test Plan:
- Reset then idle: after rst, expect empty=1, count=0, pop_valid=0, push_ready=1.
- Sorting with FIFO ties: push ranks 5,2,9,2 with data A,B,C,D on consecutive cycles, then pop 4 times -> data order B,D,A,C; ranks 2,2,5,9; count goes 4,3,2,1,0.
- Concurrent push+pop, DEPTH=4:
  - queue holds ranks 1,3,7; push rank 4 with pop_ready=1 in the same cycle;
  - expect popped rank 1 that cycle, next cycle contents 3,4,7, count=3;
  - push rank 0 with pop -> head becomes 0.
- Full boundary, DEPTH=4, macro off:
  - fill with 4 pushes -> full=1, push_ready=0 while pop_ready=0; extra push ignored, count stays 4;
  - push with pop_ready=1 -> accepted, count stays 4.
- Eviction, PIFO_EVICT_EN, DEPTH=4:
  - full with ranks 1,2,3,8 (tail data T); push rank 5 data N;
  - next cycle evict_valid=1, evict_data=T; contents 1,2,3,5;
  - then push rank 9 data M -> evict_valid=1, evict_data=M, contents unchanged.
- Reset mid-operation: with 3 entries, assert rst together with push_valid and pop_ready -> next cycle count=0, pop_valid=0, no evict pulse.
